// File: rtl/led_flow_ctrl_if.sv
// ----------------------------------------------------------------------------
// led_flow_ctrl_if
//
// Purpose:
//   Bundles the control and LED-drive signals of the LED pattern engine so
//   the controller side (keys, register block or testbench) and the engine
//   connect through one port.
//
// Parameters:
//   LED_NUM   number of LEDs in the bank
//   PWM_BITS  width of the brightness (duty) value
//
// Signals:
//   mode        2         00 rotate-left, 01 rotate-right, 10 ping-pong, 11 blink-all
//   speed       2         step period divider: STEP_CYCLES >> speed
//   pause       1         1 = freeze step counter and pattern
//   duty        PWM_BITS  brightness, only meaningful in PWM builds
//   led         LED_NUM   registered LED drive, 1 = on
//   step_pulse  1         registered one-cycle marker of each pattern step
//
// Modports:
//   master  drives the controls and observes the LEDs
//   slave   the pattern engine itself
// ----------------------------------------------------------------------------
interface led_flow_ctrl_if #(
    parameter int LED_NUM  = 4,
    parameter int PWM_BITS = 4
);

    logic [1:0]          mode;
    logic [1:0]          speed;
    logic                pause;
    logic [PWM_BITS-1:0] duty;
    logic [LED_NUM-1:0]  led;
    logic                step_pulse;

    // Control source: sets mode/speed/pause/duty, watches the LED bank.
    modport master (
        output mode,
        output speed,
        output pause,
        output duty,
        input  led,
        input  step_pulse
    );

    // Pattern engine: consumes the controls, produces the LED drive.
    modport slave (
        input  mode,
        input  speed,
        input  pause,
        input  duty,
        output led,
        output step_pulse
    );

endinterface

// File: rtl/led_flow_ctrl.sv
// ----------------------------------------------------------------------------
// led_flow_ctrl
//
// Purpose:
//   LED pattern engine for the board LED bank. Produces rotate-left,
//   rotate-right, ping-pong or blink-all patterns, advancing one step each
//   time a programmable-period tick expires. The tick period can be sped up
//   at runtime (x1/x2/x4/x8) and the whole engine can be paused.
//
// Parameters:
//   LED_NUM      number of LEDs driven (>= 2)
//   STEP_CYCLES  sys_clk cycles per step at speed = 0 (>= 16)
//   PWM_BITS     brightness counter width (PWM builds only)
//
// Ports:
//   sys_clk    in   system clock, all logic on its rising edge
//   sys_rst_n  in   asynchronous active-low reset
//   bus        slave side of led_flow_ctrl_if:
//                 mode, speed, pause, duty in; led, step_pulse out
//
// Build option:
//   LED_FLOW_PWM_EN  when defined, a free-running PWM counter gates the LEDs
//                    by 'duty'. led then lags the internal pattern by one
//                    cycle and step_pulse is delayed by one cycle to match.
//                    When undefined, 'duty' is ignored and no PWM logic exists.
// ----------------------------------------------------------------------------
module led_flow_ctrl #(
    parameter int LED_NUM     = 4,
    parameter int STEP_CYCLES = 25_000_000,
    parameter int PWM_BITS    = 4
) (
    input logic             sys_clk,
    input logic             sys_rst_n,
    led_flow_ctrl_if.slave  bus
);

    // Counter is sized to hold STEP_CYCLES-1, the largest terminal count.
    localparam int CNT_W = $clog2(STEP_CYCLES);

    localparam logic [CNT_W-1:0]   CNT_ONE        = CNT_W'(1);
    localparam logic [31:0]        STEP_CYCLES_32 = 32'(STEP_CYCLES);
    localparam logic [LED_NUM-1:0] PAT_LSB        = LED_NUM'(1);
    localparam logic [LED_NUM-1:0] PAT_MSB        = {1'b1, {(LED_NUM-1){1'b0}}};
    localparam logic [LED_NUM-1:0] PAT_ALL        = {LED_NUM{1'b1}};

    typedef enum logic [1:0] {
        MODE_ROL   = 2'b00,
        MODE_ROR   = 2'b01,
        MODE_PING  = 2'b10,
        MODE_BLINK = 2'b11
    } mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    // Parameter sanity checks, caught at elaboration time.
    if (LED_NUM < 2) begin : g_bad_led_num
        $error("led_flow_ctrl: LED_NUM must be >= 2");
    end
    if (STEP_CYCLES < 16) begin : g_bad_step_cycles
        $error("led_flow_ctrl: STEP_CYCLES must be >= 16");
    end

    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [LED_NUM-1:0] pattern_q, pattern_d;
    dir_e               dir_q, dir_d;
    mode_e              mode_q, mode_d;
    mode_e              mode_in;
    logic [31:0]        term;
    logic               step_fire;
    logic [LED_NUM-1:0] shifted;
    logic [LED_NUM-1:0] led_q;
    logic               step_pulse_q;

    assign mode_in = mode_e'(bus.mode);

    // Step tick generation. The terminal count shrinks as speed rises; the
    // >= compare means that if speed jumps up while cnt is already past the
    // new terminal, the step fires on the very next edge instead of the
    // counter running all the way round. Pause blocks the step entirely.
    always_comb begin
        term      = (STEP_CYCLES_32 >> bus.speed) - 32'd1;
        step_fire = ~bus.pause & (32'(cnt_q) >= term);
    end

    // Next count: clear on a step, otherwise increment while running, and
    // hold while paused so that resuming continues from the same point.
    always_comb begin
        cnt_d = cnt_q;
        if (!bus.pause) begin
            if (step_fire) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end
    end

    // Pattern next-state logic. The mode input is only looked at on a step.
    // A changed mode re-seeds the pattern and applies no shift on that step;
    // an unchanged mode advances the pattern by one position. For ping-pong
    // the direction flips on the step that lands on an end LED, so each end
    // is lit exactly once per pass.
    always_comb begin
        pattern_d = pattern_q;
        dir_d     = dir_q;
        mode_d    = mode_q;
        shifted   = pattern_q;

        if (step_fire) begin
            if (mode_in != mode_q) begin
                mode_d = mode_in;
                case (mode_in)
                    MODE_ROL, MODE_PING: begin
                        pattern_d = PAT_LSB;
                        dir_d     = DIR_UP;
                    end
                    MODE_ROR:   pattern_d = PAT_MSB;
                    MODE_BLINK: pattern_d = PAT_ALL;
                    default:    pattern_d = PAT_LSB;
                endcase
            end else begin
                case (mode_q)
                    MODE_ROL: begin
                        pattern_d = {pattern_q[LED_NUM-2:0], pattern_q[LED_NUM-1]};
                    end
                    MODE_ROR: begin
                        pattern_d = {pattern_q[0], pattern_q[LED_NUM-1:1]};
                    end
                    MODE_PING: begin
                        if (dir_q == DIR_UP) begin
                            shifted = {pattern_q[LED_NUM-2:0], 1'b0};
                        end else begin
                            shifted = {1'b0, pattern_q[LED_NUM-1:1]};
                        end
                        pattern_d = shifted;
                        if (shifted[LED_NUM-1]) begin
                            dir_d = DIR_DOWN;
                        end else if (shifted[0]) begin
                            dir_d = DIR_UP;
                        end
                    end
                    MODE_BLINK: begin
                        pattern_d = ~pattern_q;
                    end
                    default: begin
                        pattern_d = pattern_q;
                    end
                endcase
            end
        end
    end

    // Core state registers: tick counter, pattern, ping-pong direction and
    // the last mode that was applied. Reset puts the engine in rotate-left
    // with bit0 lit.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_q     <= '0;
            pattern_q <= PAT_LSB;
            dir_q     <= DIR_UP;
            mode_q    <= MODE_ROL;
        end else begin
            cnt_q     <= cnt_d;
            pattern_q <= pattern_d;
            dir_q     <= dir_d;
            mode_q    <= mode_d;
        end
    end

`ifdef LED_FLOW_PWM_EN

    logic [PWM_BITS-1:0] pwm_cnt_q;
    logic                pwm_on;
    logic                step_dly_q;

    // Brightness gate. All-ones duty is forced fully on, since the compare
    // alone would leave the LEDs dark for one slot out of every wrap.
    assign pwm_on = (pwm_cnt_q < bus.duty) | (&bus.duty);

    // PWM output stage. The LEDs are driven from the registered pattern, so
    // they lag it by one cycle; step_pulse goes through an extra flop so it
    // still lines up with the first cycle showing the new pattern.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pwm_cnt_q    <= '0;
            step_dly_q   <= 1'b0;
            step_pulse_q <= 1'b0;
            led_q        <= PAT_LSB;
        end else begin
            pwm_cnt_q    <= pwm_cnt_q + PWM_BITS'(1);
            step_dly_q   <= step_fire;
            step_pulse_q <= step_dly_q;
            led_q        <= pattern_q & {LED_NUM{pwm_on}};
        end
    end

`else

    // Without the PWM stage the duty input has no consumer; it is folded
    // into a single unused bit so it stays visibly accounted for.
    logic unused_duty;
    assign unused_duty = ^bus.duty;

    // Plain output stage. The LEDs take the new pattern on the same edge as
    // the step, and step_pulse marks that first cycle.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            step_pulse_q <= 1'b0;
            led_q        <= PAT_LSB;
        end else begin
            step_pulse_q <= step_fire;
            led_q        <= pattern_d;
        end
    end

`endif

    assign bus.led        = led_q;
    assign bus.step_pulse = step_pulse_q;

endmodule

// File: tb/tb_led_flow_ctrl.sv
// ----------------------------------------------------------------------------
// tb_led_flow_ctrl
//
// Purpose:
//   Directed self-checking bench for led_flow_ctrl with LED_NUM = 4 and
//   STEP_CYCLES = 16. Inputs are driven and outputs sampled on the falling
//   clock edge; expected LED patterns and pulse timing are hand-computed.
//   With LED_FLOW_PWM_EN defined, the brightness gating is exercised instead.
// ----------------------------------------------------------------------------
module tb_led_flow_ctrl;

    localparam int LED_NUM     = 4;
    localparam int STEP_CYCLES = 16;
    localparam int PWM_BITS    = 4;

    logic sys_clk   = 1'b0;
    logic sys_rst_n = 1'b0;

    int checks   = 0;
    int failures = 0;

    logic [3:0] pingSeq [7] = '{4'b0010, 4'b0100, 4'b1000, 4'b0100,
                                4'b0010, 4'b0001, 4'b0010};

    // 100 MHz-style free-running clock, rising edges at 5, 15, 25 ...
    always #5 sys_clk = ~sys_clk;

    led_flow_ctrl_if #(.LED_NUM(LED_NUM), .PWM_BITS(PWM_BITS)) bus ();

    led_flow_ctrl #(
        .LED_NUM    (LED_NUM),
        .STEP_CYCLES(STEP_CYCLES),
        .PWM_BITS   (PWM_BITS)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .bus      (bus)
    );

    // Advance n rising edges and land on the following falling edge.
    task automatic cycles(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic applyStimulus(input logic [1:0] m, input logic [1:0] s, input logic p);
        bus.mode  = m;
        bus.speed = s;
        bus.pause = p;
    endtask

    task automatic resetDut();
        @(negedge sys_clk);
        sys_rst_n = 1'b0;
        cycles(2);
        sys_rst_n = 1'b1;
    endtask

    task automatic checkOutput(input string tag, input logic [3:0] expLed, input logic expPulse);
        checks++;
        assert (bus.led === expLed) else begin
            failures++;
            $error("[TB] FAIL %s led: observed %b expected %b", tag, bus.led, expLed);
        end
        checks++;
        assert (bus.step_pulse === expPulse) else begin
            failures++;
            $error("[TB] FAIL %s step_pulse: observed %b expected %b", tag, bus.step_pulse, expPulse);
        end
    endtask

    // Keeps a broken design from hanging the run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
`ifdef LED_FLOW_PWM_EN
        int hits;
`endif
        applyStimulus(2'b00, 2'b00, 1'b0);
        bus.duty = '0;

`ifdef LED_FLOW_PWM_EN
        $display("[TB] PWM build: brightness gating");
        bus.duty = 4'd4;
        applyStimulus(2'b00, 2'b00, 1'b1);
        resetDut();
        checkOutput("pwm reset", 4'b0001, 1'b0);
        cycles(2);
        hits = 0;
        for (int i = 0; i < 16; i++) begin
            cycles(1);
            hits += int'(bus.led[0]);
        end
        checks++;
        assert (hits === 4) else begin
            failures++;
            $error("[TB] FAIL pwm duty4: observed %0d on-cycles expected 4", hits);
        end
        bus.duty = 4'd0;
        cycles(2);
        hits = 0;
        for (int i = 0; i < 16; i++) begin
            cycles(1);
            hits += int'(bus.led != 4'b0000);
        end
        checks++;
        assert (hits === 0) else begin
            failures++;
            $error("[TB] FAIL pwm duty0: observed %0d on-cycles expected 0", hits);
        end
        bus.duty = 4'd15;
        cycles(2);
        hits = 0;
        for (int i = 0; i < 16; i++) begin
            cycles(1);
            hits += int'(bus.led == 4'b0001);
        end
        checks++;
        assert (hits === 16) else begin
            failures++;
            $error("[TB] FAIL pwm duty15: observed %0d on-cycles expected 16", hits);
        end
`else
        // Rotate-left from reset, one step every 16 clocks, with wrap.
        $display("[TB] rotate-left at speed 0");
        resetDut();
        checkOutput("t1 reset", 4'b0001, 1'b0);
        cycles(15);
        checkOutput("t1 before step", 4'b0001, 1'b0);
        cycles(1);
        checkOutput("t1 step1", 4'b0010, 1'b1);
        cycles(1);
        checkOutput("t1 pulse width", 4'b0010, 1'b0);
        cycles(15);
        checkOutput("t1 step2", 4'b0100, 1'b1);
        cycles(16);
        checkOutput("t1 step3", 4'b1000, 1'b1);
        cycles(16);
        checkOutput("t1 wrap", 4'b0001, 1'b1);

        // Ping-pong from reset: first step re-seeds, then bounces.
        $display("[TB] ping-pong");
        applyStimulus(2'b10, 2'b00, 1'b0);
        resetDut();
        cycles(16);
        checkOutput("t2 reinit", 4'b0001, 1'b1);
        for (int i = 0; i < 7; i++) begin
            cycles(16);
            checkOutput($sformatf("t2 pp%0d", i), pingSeq[i], 1'b1);
        end

        // speed=2 gives a step every 4 clocks.
        $display("[TB] speed select");
        applyStimulus(2'b00, 2'b10, 1'b0);
        resetDut();
        cycles(3);
        checkOutput("t3 x4 before", 4'b0001, 1'b0);
        cycles(1);
        checkOutput("t3 x4 step1", 4'b0010, 1'b1);
        cycles(4);
        checkOutput("t3 x4 step2", 4'b0100, 1'b1);

        // Speed jump mid-count: cnt=10 already past term=1, step next edge.
        applyStimulus(2'b00, 2'b00, 1'b0);
        resetDut();
        cycles(10);
        checkOutput("t3 cnt10", 4'b0001, 1'b0);
        bus.speed = 2'b11;
        cycles(1);
        checkOutput("t3 jump step", 4'b0010, 1'b1);
        cycles(1);
        checkOutput("t3 x8 gap", 4'b0010, 1'b0);
        cycles(1);
        checkOutput("t3 x8 step", 4'b0100, 1'b1);

        // Pause at cnt=7 with a mode change held back until resume.
        $display("[TB] pause");
        applyStimulus(2'b00, 2'b00, 1'b0);
        resetDut();
        cycles(7);
        applyStimulus(2'b11, 2'b00, 1'b1);
        for (int i = 0; i < 4; i++) begin
            cycles(10);
            checkOutput($sformatf("t4 paused%0d", i), 4'b0001, 1'b0);
        end
        bus.pause = 1'b0;
        cycles(8);
        checkOutput("t4 resume before", 4'b0001, 1'b0);
        cycles(1);
        checkOutput("t4 resume reinit", 4'b1111, 1'b1);

        // Blink, then switch to rotate-right, then async reset mid-run.
        $display("[TB] blink and rotate-right");
        cycles(16);
        checkOutput("t5 blink off", 4'b0000, 1'b1);
        cycles(16);
        checkOutput("t5 blink on", 4'b1111, 1'b1);
        bus.mode = 2'b01;
        cycles(16);
        checkOutput("t5 ror reinit", 4'b1000, 1'b1);
        cycles(16);
        checkOutput("t5 ror step", 4'b0100, 1'b1);
        sys_rst_n = 1'b0;
        #1;
        checkOutput("t5 async reset", 4'b0001, 1'b0);
        cycles(2);
        sys_rst_n = 1'b1;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
